// File: rtl/reset_sequencer.sv
// Reset sequencer: holds every downstream reset domain in reset for a
// minimum period, then releases the domains one at a time in index order,
// waiting for each domain's ready (or a timeout) before stepping to the next.
// A software request in the completed state re-runs the whole sequence.
module reset_sequencer #(
    parameter int   NUM_DOMAINS    = 4,
    parameter int   HOLD_CYCLES    = 16,
    parameter int   STEP_CYCLES    = 8,
    parameter int   TIMEOUT_CYCLES = 256,
    parameter logic RST_POL        = 1'b0
) (
    input  logic                           clk,
    input  logic                           i_rstn,
    input  logic                           i_sw_req,
    input  logic [NUM_DOMAINS-1:0]         i_ready,
    output logic [NUM_DOMAINS-1:0]         o_rst,
    output logic                           o_busy,
    output logic                           o_done,
    output logic [$clog2(NUM_DOMAINS):0]   o_stage,
    output logic [NUM_DOMAINS-1:0]         o_timeout_err
);

    localparam int MAX_HS = (HOLD_CYCLES > STEP_CYCLES) ? HOLD_CYCLES : STEP_CYCLES;
    localparam int MAX_C  = (MAX_HS > TIMEOUT_CYCLES) ? MAX_HS : TIMEOUT_CYCLES;
    localparam int CW     = $clog2(MAX_C + 1);
    localparam int SW     = $clog2(NUM_DOMAINS) + 1;

    typedef enum logic [1:0] {
        S_HOLD,
        S_WAIT_RDY,
        S_STEP,
        S_RUN
    } state_t;

    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic [NUM_DOMAINS-1:0] rst_q;
    logic                   busy_q;
    logic                   done_q;
    logic [SW-1:0]          stage_q;
    logic [NUM_DOMAINS-1:0] err_q;

    // One-hot select of the domain currently being waited on, and the next one.
    logic [NUM_DOMAINS-1:0] cur_mask;
    logic [NUM_DOMAINS-1:0] nxt_mask;
    logic                   rdy_sel;
    logic                   timeout_hit;
    logic                   last_dom;

    assign cur_mask    = NUM_DOMAINS'(1) << stage_q;
    assign nxt_mask    = NUM_DOMAINS'(1) << (stage_q + SW'(1));
    assign rdy_sel     = |(i_ready & cur_mask);
    assign last_dom    = (stage_q == SW'(NUM_DOMAINS - 1));
    // Ready wins over a timeout that expires on the same edge.
    assign timeout_hit = (TIMEOUT_CYCLES > 0) && !rdy_sel &&
                         (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    // Drive the selected reset bits to their released level, leaving others alone.
    function automatic logic [NUM_DOMAINS-1:0] release_bits(
        input logic [NUM_DOMAINS-1:0] cur,
        input logic [NUM_DOMAINS-1:0] m
    );
        return RST_POL ? (cur & ~m) : (cur | m);
    endfunction

    // Sequencer FSM with registered outputs; i_rstn overrides every state.
    always_ff @(posedge clk) begin
        if (!i_rstn) begin
            state_q <= S_HOLD;
            cnt_q   <= '0;
            rst_q   <= {NUM_DOMAINS{RST_POL}};
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            stage_q <= '0;
            err_q   <= '0;
        end else begin
            case (state_q)
                S_HOLD: begin
                    if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
                        cnt_q   <= '0;
                        rst_q   <= release_bits(rst_q, NUM_DOMAINS'(1));
                        state_q <= S_WAIT_RDY;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_WAIT_RDY: begin
                    if (rdy_sel || timeout_hit) begin
                        cnt_q <= '0;
                        if (timeout_hit) begin
                            err_q <= err_q | cur_mask;
                        end
                        if (last_dom) begin
                            state_q <= S_RUN;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            stage_q <= SW'(NUM_DOMAINS);
                            rst_q   <= {NUM_DOMAINS{~RST_POL}};
                        end else begin
                            state_q <= S_STEP;
                        end
                    end else if (TIMEOUT_CYCLES > 0) begin
                        // With no timeout the counter stays parked so it can never wrap.
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_STEP: begin
                    if (cnt_q == CW'(STEP_CYCLES - 1)) begin
                        cnt_q   <= '0;
                        rst_q   <= release_bits(rst_q, nxt_mask);
                        stage_q <= stage_q + SW'(1);
                        state_q <= S_WAIT_RDY;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_RUN: begin
                    if (i_sw_req) begin
                        state_q <= S_HOLD;
                        cnt_q   <= '0;
                        rst_q   <= {NUM_DOMAINS{RST_POL}};
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        stage_q <= '0;
                        err_q   <= '0;
                    end
                end
                default: begin
                    state_q <= S_HOLD;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign o_rst         = rst_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_stage       = stage_q;
    assign o_timeout_err = err_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: three instances (no-timeout, timeout=8, and a
// single-domain active-high variant), a vector table, hand-written corner
// sequences and a randomized run against a schedule-based reference model.
module tb_reset_sequencer;

    localparam int H  = 4;
    localparam int S  = 2;
    localparam int TB = 8;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       sw_req = 1'b0;
    logic [3:0] rdy = 4'hF;
    logic       rstn_c = 1'b0;
    logic       sw_c = 1'b0;
    logic       rdy_c = 1'b1;

    logic [3:0] rst_a, err_a, rst_b, err_b;
    logic [2:0] stg_a, stg_b;
    logic       busy_a, done_a, busy_b, done_b;
    logic       rst_c, busy_c, done_c, stg_c, err_c;

    always #5 clk = ~clk;

    reset_sequencer #(.NUM_DOMAINS(4), .HOLD_CYCLES(H), .STEP_CYCLES(S),
                      .TIMEOUT_CYCLES(0), .RST_POL(1'b0)) dut_a (
        .clk(clk), .i_rstn(rstn), .i_sw_req(sw_req), .i_ready(rdy),
        .o_rst(rst_a), .o_busy(busy_a), .o_done(done_a), .o_stage(stg_a),
        .o_timeout_err(err_a));

    reset_sequencer #(.NUM_DOMAINS(4), .HOLD_CYCLES(H), .STEP_CYCLES(S),
                      .TIMEOUT_CYCLES(TB), .RST_POL(1'b0)) dut_b (
        .clk(clk), .i_rstn(rstn), .i_sw_req(sw_req), .i_ready(rdy),
        .o_rst(rst_b), .o_busy(busy_b), .o_done(done_b), .o_stage(stg_b),
        .o_timeout_err(err_b));

    reset_sequencer #(.NUM_DOMAINS(1), .HOLD_CYCLES(1), .STEP_CYCLES(1),
                      .TIMEOUT_CYCLES(0), .RST_POL(1'b1)) dut_c (
        .clk(clk), .i_rstn(rstn_c), .i_sw_req(sw_c), .i_ready(rdy_c),
        .o_rst(rst_c), .o_busy(busy_c), .o_done(done_c), .o_stage(stg_c),
        .o_timeout_err(err_c));

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: ready history per edge and sequence start edge.
    logic [3:0] rdy_h [0:8191];
    int         t_now = -1;
    int         s_a = 0;
    int         s_b = 0;
    bit         started = 0;

    typedef struct {
        logic       rn;
        logic       sw;
        logic [3:0] rd;
        logic [3:0] rst;
        logic       busy;
        logic       done;
        logic [2:0] stg;
        logic [3:0] err;
    } vec_t;

    vec_t tbl [24];

    function automatic logic [12:0] pk(input logic [3:0] r, input logic b,
                                       input logic d, input logic [2:0] s,
                                       input logic [3:0] e);
        return {r, b, d, s, e};
    endfunction

    task automatic chk(input string nm, input logic [12:0] act, input logic [12:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at edge %0d: got %h, want %h", nm, t_now, act, exp);
        end
    endtask

    // Schedule view: domain 0 releases H edges after the start edge; each
    // domain k is answered at its first ready edge (or at release+T), and the
    // next release comes S edges after that answer.
    function automatic void model(input int tmo, input int s, input int t,
                                  output logic [3:0] rel, output logic done,
                                  output logic [2:0] stg, output logic [3:0] err);
        int r;
        int e;
        bit to;
        rel = '0; done = 1'b0; stg = '0; err = '0;
        if (t < s + H) return;
        r = s + H;
        for (int k = 0; k < 4; k++) begin
            rel[k] = 1'b1;
            stg = 3'(k);
            e = -1;
            to = 0;
            for (int x = r + 1; x <= t; x++) begin
                if (rdy_h[x][k]) begin e = x; break; end
                if (tmo > 0 && x == r + tmo) begin e = x; to = 1; break; end
            end
            if (e < 0) return;
            if (to) err[k] = 1'b1;
            if (k == 3) begin done = 1'b1; stg = 3'd4; return; end
            r = e + S;
            if (r > t) return;
        end
    endfunction

    task automatic step(input logic rn, input logic sw, input logic [3:0] rd);
        logic [3:0] r, e;
        logic       d;
        logic [2:0] g;
        @(negedge clk);
        rstn = rn; sw_req = sw; rdy = rd;
        @(posedge clk);
        t_now++;
        rdy_h[t_now] = rd;
        if (!rn) begin
            s_a = t_now; s_b = t_now; started = 1;
        end else if (started && sw) begin
            model(0, s_a, t_now - 1, r, d, g, e);
            if (d) s_a = t_now;
            model(TB, s_b, t_now - 1, r, d, g, e);
            if (d) s_b = t_now;
        end
        #1;
        if (started) begin
            model(0, s_a, t_now, r, d, g, e);
            chk("modelA", pk(rst_a, busy_a, done_a, stg_a, err_a), pk(r, ~d, d, g, e));
            model(TB, s_b, t_now, r, d, g, e);
            chk("modelB", pk(rst_b, busy_b, done_b, stg_b, err_b), pk(r, ~d, d, g, e));
        end
    endtask

    function automatic logic [12:0] pkc();
        return pk({3'b0, rst_c}, busy_c, done_c, {2'b0, stg_c}, {3'b0, err_c});
    endfunction

    initial begin
        logic [3:0] thr [4];
        logic [3:0] rv;
        int         sw_mode;

        // Ready tied high from a reset edge (edge 0), then a sw_req in RUN
        // and an ignored sw_req during STEP.
        tbl[0]  = '{1'b0, 1'b0, 4'hF, 4'b0000, 1'b1, 1'b0, 3'd0, 4'h0};
        tbl[1]  = '{1'b1, 1'b0, 4'hF, 4'b0000, 1'b1, 1'b0, 3'd0, 4'h0};
        tbl[2]  = '{1'b1, 1'b0, 4'hF, 4'b0000, 1'b1, 1'b0, 3'd0, 4'h0};
        tbl[3]  = '{1'b1, 1'b0, 4'hF, 4'b0000, 1'b1, 1'b0, 3'd0, 4'h0};
        tbl[4]  = '{1'b1, 1'b0, 4'hF, 4'b0001, 1'b1, 1'b0, 3'd0, 4'h0};
        tbl[5]  = '{1'b1, 1'b0, 4'hF, 4'b0001, 1'b1, 1'b0, 3'd0, 4'h0};
        tbl[6]  = '{1'b1, 1'b0, 4'hF, 4'b0001, 1'b1, 1'b0, 3'd0, 4'h0};
        tbl[7]  = '{1'b1, 1'b0, 4'hF, 4'b0011, 1'b1, 1'b0, 3'd1, 4'h0};
        tbl[8]  = '{1'b1, 1'b0, 4'hF, 4'b0011, 1'b1, 1'b0, 3'd1, 4'h0};
        tbl[9]  = '{1'b1, 1'b0, 4'hF, 4'b0011, 1'b1, 1'b0, 3'd1, 4'h0};
        tbl[10] = '{1'b1, 1'b0, 4'hF, 4'b0111, 1'b1, 1'b0, 3'd2, 4'h0};
        tbl[11] = '{1'b1, 1'b0, 4'hF, 4'b0111, 1'b1, 1'b0, 3'd2, 4'h0};
        tbl[12] = '{1'b1, 1'b0, 4'hF, 4'b0111, 1'b1, 1'b0, 3'd2, 4'h0};
        tbl[13] = '{1'b1, 1'b0, 4'hF, 4'b1111, 1'b1, 1'b0, 3'd3, 4'h0};
        tbl[14] = '{1'b1, 1'b0, 4'hF, 4'b1111, 1'b0, 1'b1, 3'd4, 4'h0};
        tbl[15] = '{1'b1, 1'b0, 4'hF, 4'b1111, 1'b0, 1'b1, 3'd4, 4'h0};
        tbl[16] = '{1'b1, 1'b1, 4'hF, 4'b0000, 1'b1, 1'b0, 3'd0, 4'h0};
        tbl[17] = '{1'b1, 1'b0, 4'hF, 4'b0000, 1'b1, 1'b0, 3'd0, 4'h0};
        tbl[18] = '{1'b1, 1'b0, 4'hF, 4'b0000, 1'b1, 1'b0, 3'd0, 4'h0};
        tbl[19] = '{1'b1, 1'b0, 4'hF, 4'b0000, 1'b1, 1'b0, 3'd0, 4'h0};
        tbl[20] = '{1'b1, 1'b0, 4'hF, 4'b0001, 1'b1, 1'b0, 3'd0, 4'h0};
        tbl[21] = '{1'b1, 1'b0, 4'hF, 4'b0001, 1'b1, 1'b0, 3'd0, 4'h0};
        tbl[22] = '{1'b1, 1'b1, 4'hF, 4'b0001, 1'b1, 1'b0, 3'd0, 4'h0};
        tbl[23] = '{1'b1, 1'b0, 4'hF, 4'b0011, 1'b1, 1'b0, 3'd1, 4'h0};

        for (int i = 0; i < 24; i++) begin
            step(tbl[i].rn, tbl[i].sw, tbl[i].rd);
            chk("tblA", pk(rst_a, busy_a, done_a, stg_a, err_a),
                pk(tbl[i].rst, tbl[i].busy, tbl[i].done, tbl[i].stg, tbl[i].err));
            chk("tblB", pk(rst_b, busy_b, done_b, stg_b, err_b),
                pk(tbl[i].rst, tbl[i].busy, tbl[i].done, tbl[i].stg, tbl[i].err));
            // Single-domain, active-high instance runs alongside the first rows.
            case (i)
                0: begin chk("c_reset", pkc(), pk(4'd1, 1'b1, 1'b0, 3'd0, 4'd0)); rstn_c = 1'b1; end
                1: chk("c_rel", pkc(), pk(4'd0, 1'b1, 1'b0, 3'd0, 4'd0));
                2: begin chk("c_done", pkc(), pk(4'd0, 1'b0, 1'b1, 3'd1, 4'd0)); sw_c = 1'b1; end
                3: begin chk("c_swreq", pkc(), pk(4'd1, 1'b1, 1'b0, 3'd0, 4'd0)); sw_c = 1'b0; end
                4: chk("c_rel2", pkc(), pk(4'd0, 1'b1, 1'b0, 3'd0, 4'd0));
                default: ;
            endcase
        end

        // Domain 1 ready late: rises so it is sampled at edge 20.
        step(1'b0, 1'b0, 4'hF);
        for (int e = 1; e <= 19; e++) step(1'b1, 1'b0, 4'b1101);
        chk("late_a_hold", {rst_a, 6'd0, stg_a}, {4'b0011, 6'd0, 3'd1});
        chk("late_b_tmo", {rst_b, 5'd0, err_b}, {4'b0111, 5'd0, 4'b0010});
        step(1'b1, 1'b0, 4'hF);
        step(1'b1, 1'b0, 4'hF);
        chk("late_a_e21", {rst_a, 6'd0, stg_a}, {4'b0011, 6'd0, 3'd1});
        chk("late_b_done", {err_b, 8'd0, done_b}, {4'b0010, 8'd0, 1'b1});
        step(1'b1, 1'b0, 4'hF);
        chk("late_a_e22", {rst_a, 6'd0, stg_a}, {4'b0111, 6'd0, 3'd2});

        // Domain 2 never ready: B times out, A waits forever.
        step(1'b0, 1'b0, 4'hF);
        for (int e = 1; e <= 17; e++) step(1'b1, 1'b0, 4'b1011);
        chk("tmo_e17", {rst_b, 5'd0, err_b}, {4'b0111, 5'd0, 4'b0000});
        step(1'b1, 1'b0, 4'b1011);
        chk("tmo_e18", {rst_b, 5'd0, err_b}, {4'b0111, 5'd0, 4'b0100});
        step(1'b1, 1'b0, 4'b1011);
        step(1'b1, 1'b0, 4'b1011);
        chk("tmo_rel3", {rst_b, 8'd0, done_b}, {4'b1111, 8'd0, 1'b0});
        step(1'b1, 1'b0, 4'b1011);
        chk("tmo_done", pk(rst_b, busy_b, done_b, stg_b, err_b), pk(4'b1111, 1'b0, 1'b1, 3'd4, 4'b0100));
        for (int e = 22; e <= 25; e++) step(1'b1, 1'b0, 4'b1011);
        chk("tmo_sticky", pk(rst_b, busy_b, done_b, stg_b, err_b), pk(4'b1111, 1'b0, 1'b1, 3'd4, 4'b0100));
        chk("nowait_a", pk(rst_a, busy_a, done_a, stg_a, err_a), pk(4'b0111, 1'b1, 1'b0, 3'd2, 4'b0000));

        // One-cycle reset while A sits in WAIT_RDY(2), then a clean restart.
        step(1'b0, 1'b0, 4'hF);
        chk("abort_a", pk(rst_a, busy_a, done_a, stg_a, err_a), pk(4'b0000, 1'b1, 1'b0, 3'd0, 4'b0000));
        for (int e = 1; e <= 14; e++) begin
            step(1'b1, 1'b0, 4'hF);
            if (e == 3)  chk("rst_e3", {9'd0, rst_a}, {9'd0, 4'b0000});
            if (e == 4)  chk("rst_e4", {9'd0, rst_a}, {9'd0, 4'b0001});
            if (e == 13) chk("rst_e13", {rst_a, 6'd0, busy_a, done_a, 1'b0}, {4'b1111, 6'd0, 1'b1, 1'b0, 1'b0});
            if (e == 14) chk("rst_e14", pk(rst_a, busy_a, done_a, stg_a, err_a), pk(4'b1111, 1'b0, 1'b1, 3'd4, 4'b0000));
        end

        // Randomized traffic checked by the model inside step().
        sw_mode = 0;
        for (int k = 0; k < 4; k++) thr[k] = 4'd10;
        for (int n = 0; n < 2500; n++) begin
            if (n % 150 == 0) begin
                for (int k = 0; k < 4; k++) thr[k] = 4'($urandom_range(0, 10));
                sw_mode = $urandom_range(0, 2);
            end
            for (int k = 0; k < 4; k++) rv[k] = ($urandom_range(1, 10) <= int'(thr[k]));
            step(($urandom_range(0, 199) != 0),
                 (sw_mode == 2) ? 1'b1 : (sw_mode == 1) ? ($urandom_range(0, 15) == 0) : 1'b0,
                 rv);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Single-clock controller that sequences reset release across NUM_DOMAINS downstream reset domains.
- Holds all domain resets asserted for a minimum period, then releases them one at a time in index order (0 first).
- Each domain must report ready, or time out, before the next domain is released.
- Sits behind the reset synchronizers in each clock's reset tree; also provides a software-triggered re-sequence.

Parameters:
NUM_DOMAINS, 4, number of sequenced reset outputs; legal 1..16
HOLD_CYCLES, 16, cycles all outputs stay asserted after reset/soft reset before domain 0 releases; min 1
STEP_CYCLES, 8, cycles from domain k ready sampled to domain k+1 release; min 1
TIMEOUT_CYCLES, 256, max cycles waiting for i_ready[k]; 0 = wait forever
RST_POL, 1'b0, asserted level of o_rst bits

Ports:
clk  input  1  clock
i_rstn  input  1  synchronous active-low reset
i_sw_req  input  1  software re-sequence request, sampled per cycle
i_ready  input  NUM_DOMAINS  domain k reports out-of-reset/ready; level
o_rst  output  NUM_DOMAINS  domain resets, asserted = RST_POL
o_busy  output  1  sequence in progress
o_done  output  1  all domains released and sequence complete
o_stage  output  $clog2(NUM_DOMAINS)+1  index of domain currently being released/waited on; NUM_DOMAINS when done
o_timeout_err  output  NUM_DOMAINS  sticky per-domain timeout flag

Behaviour:
- Reset: one clock (clk); reset is synchronous and active-low (i_rstn sampled only at posedge clk).
- While i_rstn=0 at an edge, after that edge: state HOLD, counter=0, o_rst all = RST_POL, o_busy=1, o_done=0, o_stage=0, o_timeout_err=0.
- Reset mid-sequence aborts immediately to these values; i_rstn has priority over everything.
- States: HOLD, WAIT_RDY, STEP, RUN.
- HOLD: count edges with i_rstn=1 (edge 1 = first such). After edge HOLD_CYCLES, o_rst[0] = ~RST_POL and state becomes WAIT_RDY for k=0.
- WAIT_RDY(k):
  - i_ready[k] sampled 1 at edge e: clear counter, go to STEP. i_ready[k] already high counts; detection is at the first WAIT_RDY edge.
  - If TIMEOUT_CYCLES>0 and TIMEOUT_CYCLES edges pass without ready: set o_timeout_err[k]=1, go to STEP (sequence continues).
  - If k = NUM_DOMAINS-1, go to RUN instead of STEP.
- STEP: after edge e+STEP_CYCLES, o_rst[k+1] = ~RST_POL, o_stage=k+1, state WAIT_RDY(k+1).
- RUN: o_busy=0, o_done=1, o_stage=NUM_DOMAINS, all o_rst deasserted. Outputs change at the same edge that enters RUN.
- Released domains stay released. Later deassertion of i_ready is ignored until the next re-sequence.
- i_sw_req:
  - Accepted only in RUN. Sampled 1 at edge → after that edge, all o_rst = RST_POL, o_timeout_err cleared, o_busy=1, o_done=0, o_stage=0, state HOLD, counter=0; full sequence repeats.
  - Ignored in HOLD/WAIT_RDY/STEP (no queuing).
  - Held high continuously: re-triggers at each RUN entry edge+1.
- o_rst is always registered, glitch-free, and changes in one bit at a time during release. Exception: all bits assert together on reset or accepted i_sw_req.
- Counter width: clog2(max(HOLD_CYCLES,STEP_CYCLES,TIMEOUT_CYCLES)+1); it must not wrap.
- NUM_DOMAINS=1: HOLD → WAIT_RDY(0) → RUN, with no STEP.

Test Plan:
- NUM_DOMAINS=4, HOLD=4, STEP=2, TIMEOUT=0, i_ready tied 1, release i_rstn before edge 1: o_rst[0] deasserts after edge 4; o_rst[1] after edge 7; o_rst[2] after edge 10; o_rst[3] after edge 13; o_done=1, o_busy=0 after edge 14; o_stage=4.
- Same config, i_ready[1] raised at edge 20: o_rst[2] stays asserted; deasserts after edge 22; o_stage=1 until then.
- TIMEOUT=8, i_ready[2] never asserts: o_timeout_err=4'b0100 after the 8th WAIT_RDY edge; o_rst[3] releases STEP later; o_done=1; err sticky in RUN.
- In RUN, pulse i_sw_req: next edge all o_rst=0 (RST_POL=0), err cleared, o_busy=1; sequence repeats with identical timing. An i_sw_req pulse during STEP is ignored.
- i_rstn=0 for 1 cycle while in WAIT_RDY(2): after that edge all o_rst asserted, o_stage=0, o_done=0; restart timing matches scenario 1.
- NUM_DOMAINS=1, RST_POL=1, HOLD=1, i_ready=1: o_rst=1 in reset; 0 after edge 1; o_done=1 after edge 2.
